// File: rtl/exp_lut_arbiter.sv
// Round-robin arbiter that shares one combinational q32.32 exp LUT between N_REQ requesters.
// The response is two cycles after the grant. Optional stats counters: define EXP_ARB_STATS_EN.
module exp_lut_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ*64-1:0]   i_req_value,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [63:0]           o_lut_input,
  input  logic [63:0]           i_lut_exp,
  output logic                  o_rsp_valid,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [63:0]           o_rsp_data,
  input  logic                  i_rsp_ready,
  output logic [CNT_W-1:0]      o_grant_cnt,
  output logic [CNT_W-1:0]      o_oor_cnt
);

  logic            adv, found, hs, s1_valid;
  logic [ID_W-1:0] rr_ptr, sel, s1_id;
  logic [63:0]     req_op;

  // S1 and S2 only move together, and only when the response slot is free or being drained.
  assign adv = !o_rsp_valid || i_rsp_ready;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (adv && !i_rst && found) o_req_ready[sel] = 1'b1;
  end

  assign hs     = |(o_req_ready & i_req_valid);
  assign req_op = i_req_value[int'(sel)*64 +: 64];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr      <= '0;
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      o_lut_input <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_data  <= '0;
    end else begin
      if (hs) rr_ptr <= (sel == ID_W'(N_REQ-1)) ? '0 : sel + 1'b1;
      if (adv) begin
        s1_valid    <= hs;
        o_rsp_valid <= s1_valid;
        if (hs) begin
          o_lut_input <= req_op;
          s1_id       <= sel;
        end
        if (s1_valid) begin
          o_rsp_id   <= s1_id;
          o_rsp_data <= i_lut_exp;
        end
      end
    end
  end

`ifdef EXP_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt, oor_cnt;
  logic             oor;

  // |x| > 1.0 in signed q32.32
  assign oor = ($signed(req_op) > $signed(64'h0000_0001_0000_0000)) ||
               ($signed(req_op) < $signed(64'hFFFF_FFFF_0000_0000));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_cnt <= '0;
      oor_cnt   <= '0;
    end else if (hs) begin
      if (!(&grant_cnt))      grant_cnt <= grant_cnt + 1'b1;
      if (oor && !(&oor_cnt)) oor_cnt   <= oor_cnt + 1'b1;
    end
  end

  assign o_grant_cnt = grant_cnt;
  assign o_oor_cnt   = oor_cnt;
`else
  assign o_grant_cnt = '0;
  assign o_oor_cnt   = '0;
`endif

endmodule

// File: tb/tb_exp_lut_arbiter.sv
// Directed bench for exp_lut_arbiter; LUT modelled as exp = input + 0x10.
module tb_exp_lut_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*64-1:0] req_value;
  logic [N-1:0]  req_ready;
  logic [63:0]   lut_input, lut_exp, rsp_data;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   grant_cnt, oor_cnt;

  int checks = 0;
  int failures = 0;

  logic [1:0]  exp_id_q[$];
  logic [63:0] exp_data_q[$];

  always #5 clk = ~clk;

  assign lut_exp = lut_input + 64'h10;

  exp_lut_arbiter #(.N_REQ(N), .ID_W(2), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_value(req_value),
    .o_req_ready(req_ready), .o_lut_input(lut_input), .i_lut_exp(lut_exp),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
    .i_rsp_ready(rsp_ready), .o_grant_cnt(grant_cnt), .o_oor_cnt(oor_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted request must come back once, in grant order.
  always @(negedge clk) begin
    if (rst) begin
      exp_id_q.delete();
      exp_data_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_id_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
        else begin
          chk("rsp_id", 64'(rsp_id), 64'(exp_id_q.pop_front()));
          chk("rsp_data", rsp_data, exp_data_q.pop_front());
        end
      end
      for (int k = 0; k < N; k++)
        if (req_ready[k] && req_valid[k]) begin
          exp_id_q.push_back(2'(k));
          exp_data_q.push_back(req_value[k*64 +: 64] + 64'h10);
        end
    end
  end

  logic [3:0] rot_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    rst = 1'b1; req_valid = '1; req_value = '0; rsp_ready = 1'b1;
    step; step;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_lut_input", lut_input, 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
    chk("rst_oor_cnt", 64'(oor_cnt), 64'd0);

    // single request latency
    rst = 1'b0; req_valid = 4'b0001; req_value[63:0] = 64'h0000_0000_8000_0000;
    #1 chk("lat_ready", 64'(req_ready), 64'h1);
    step; req_valid = '0;
    #1 chk("lat_lut_input", lut_input, 64'h0000_0000_8000_0000);
    chk("lat_rsp_valid_early", 64'(rsp_valid), 64'd0);
    step;
    chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("lat_rsp_id", 64'(rsp_id), 64'd0);
    chk("lat_rsp_data", rsp_data, 64'h0000_0000_8000_0010);
    step; step;

    // rotation with all requesters valid from rr_ptr=0
    rst = 1'b1; step; rst = 1'b0;
    for (int k = 0; k < N; k++) req_value[k*64 +: 64] = 64'((k+1) * 'h100);
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_grant", 64'(req_ready), 64'(rot_exp[i]));
      step;
    end

    // stall: S2 holds grant 4 (req0), S1 holds grant 5 (req1)
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rsp_id", 64'(rsp_id), 64'd0);
      chk("stall_rsp_data", rsp_data, 64'h110);
      chk("stall_lut_input", lut_input, 64'h200);
      step;
    end
    rsp_ready = 1'b1; req_valid = '0;
    step; step; step;
    chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);

    // rr_ptr is 2: req3 wins, then wrap to 0 picks req1
    req_valid = 4'b1010;
    #1 chk("wrap_grant3", 64'(req_ready), 64'b1000);
    step;
    #1 chk("wrap_grant1", 64'(req_ready), 64'b0010);
    step; req_valid = '0;
    step; step; step;

    // mid-flight reset with two requests in the pipe
    req_valid = 4'b0001; rsp_ready = 1'b0;
    step; step; req_valid = '0;
    #1 chk("mid_rsp_valid_pre", 64'(rsp_valid), 64'd1);
    rst = 1'b1; step; rst = 1'b0; rsp_ready = 1'b1;
    #1 chk("mid_rsp_valid0", 64'(rsp_valid), 64'd0);
    step;
    chk("mid_rsp_valid1", 64'(rsp_valid), 64'd0);
    step;
    chk("mid_rsp_valid2", 64'(rsp_valid), 64'd0);
    req_valid = 4'b1111;
    #1 chk("mid_rr_ptr0", 64'(req_ready), 64'b0001);
    req_valid = '0;

    // stats: 2.0, -2.0, 0.5 on req0
    rst = 1'b1; step; rst = 1'b0;
    req_valid = 4'b0001;
    req_value[63:0] = 64'h0000_0002_0000_0000; step;
    req_value[63:0] = 64'hFFFF_FFFE_0000_0000; step;
    req_value[63:0] = 64'h0000_0000_8000_0000; step;
    req_valid = '0;
    step; step; step;
`ifdef EXP_ARB_STATS_EN
    chk("grant_cnt", 64'(grant_cnt), 64'd3);
    chk("oor_cnt", 64'(oor_cnt), 64'd2);
`else
    chk("grant_cnt", 64'(grant_cnt), 64'd0);
    chk("oor_cnt", 64'(oor_cnt), 64'd0);
`endif
    chk("sb_empty", 64'(exp_id_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
